imm_encoder: RTL and testbench

Pipelined RISC-V immediate packer: the inverse of the decode-side immediate extender. It takes a 32-bit signed immediate, an immediate format, and a base instruction word carrying opcode/register/funct fields. It scatters the immediate into the format's bit positions, checks representability and alignment, and delivers the finished instruction word through a valid/ready output buffer. It sits in the boot/self-test program generator that writes instruction memory. Its output must round-trip through the core's decode-side extender.

---
 rtl/riscv_pkg.sv | 73 +++++++
 rtl/sync_fifo.sv | 58 +++++
 rtl/imm_encoder.sv | 97 +++++++++
 tb/tb_imm_encoder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`timescale 1ns/1ps
// Shared RISC-V immediate definitions: format enum, FIFO entry layout and
// the combinational immediate packer used by the encoder stage.
package riscv_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        err_range;
    logic        err_align;
  } fifo_entry_t;

  localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

  // True when every bit of the slice is the same (value fits after sign-extension).
  function automatic logic all_equal21(input logic [20:0] v);
    return (&v) | ~(|v);
  endfunction

  function automatic logic all_equal20(input logic [19:0] v);
    return (&v) | ~(|v);
  endfunction

  function automatic logic all_equal12(input logic [11:0] v);
    return (&v) | ~(|v);
  endfunction

  // Scatter imm into the format's bit positions; non-immediate bits come from base.
  // The word is always packed from the truncated bits, even when a flag is raised.
  function automatic fifo_entry_t pack_imm(input imm_src_t    src,
                                           input logic [31:0] imm,
                                           input logic [31:0] base);
    fifo_entry_t e;
    e.instr     = base;
    e.err_range = 1'b0;
    e.err_align = 1'b0;
    case (src)
      IMM_I: begin
        e.instr[31:20] = imm[11:0];
        e.err_range    = ~all_equal21(imm[31:11]);
      end
      IMM_S: begin
        e.instr[31:25] = imm[11:5];
        e.instr[11:7]  = imm[4:0];
        e.err_range    = ~all_equal21(imm[31:11]);
      end
      IMM_B: begin
        e.instr[31]    = imm[12];
        e.instr[7]     = imm[11];
        e.instr[30:25] = imm[10:5];
        e.instr[11:8]  = imm[4:1];
        e.err_range    = ~all_equal20(imm[31:12]);
        e.err_align    = imm[0];
      end
      default: begin
        e.instr[31]    = imm[20];
        e.instr[19:12] = imm[19:12];
        e.instr[20]    = imm[11];
        e.instr[30:21] = imm[10:1];
        e.err_range    = ~all_equal12(imm[31:20]);
        e.err_align    = imm[0];
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
`timescale 1ns/1ps
// Generic single-clock FIFO with occupancy count; head entry shown on dout.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1,
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_q];
  assign count   = cnt_q;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= ptr_next(wr_q);
      end
      if (do_pop) rd_q <= ptr_next(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/imm_encoder.sv
`timescale 1ns/1ps
// Pipelined RISC-V immediate packer: stage register feeding a DEPTH-1 output FIFO.
module imm_encoder
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  imm_src,
  input  logic [31:0] imm,
  input  logic [31:0] base_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err_range,
  output logic        out_err_align,
  output logic [7:0]  err_count
);

  localparam int unsigned FDEPTH = DEPTH - 1;
  localparam int unsigned CW     = $clog2(FDEPTH + 1);

  logic        stage_valid_q, stage_valid_d;
  imm_src_t    stage_src_q;
  logic [31:0] stage_imm_q, stage_base_q;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic        accept, stage_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   occupancy;
  fifo_entry_t stage_entry, in_entry, head;

  // in_ready looks only at registered occupancy, so out_ready never reaches it.
  assign occupancy  = {1'b0, fifo_cnt} + (CW + 1)'(stage_valid_q);
  assign in_ready   = (occupancy < (CW + 1)'(DEPTH));
  assign accept     = in_valid & in_ready;
  assign fifo_pop   = out_valid & out_ready;
  // Stage drains every cycle unless the FIFO is full and not popping.
  assign stage_push = stage_valid_q & (~fifo_full | fifo_pop);

  assign stage_entry = pack_imm(stage_src_q, stage_imm_q, stage_base_q);
  assign in_entry    = pack_imm(imm_src_t'(imm_src), imm, base_instr);

  // Stage occupancy and error-counter next state.
  always_comb begin
    stage_valid_d = stage_valid_q;
    err_cnt_d     = err_cnt_q;
    if (stage_push) stage_valid_d = 1'b0;
    if (accept)     stage_valid_d = 1'b1;
    if (accept && (in_entry.err_range || in_entry.err_align) && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  // Stage-1 request register and saturating error counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_valid_q <= 1'b0;
      stage_src_q   <= IMM_I;
      stage_imm_q   <= '0;
      stage_base_q  <= '0;
      err_cnt_q     <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      err_cnt_q     <= err_cnt_d;
      if (accept) begin
        stage_src_q  <= imm_src_t'(imm_src);
        stage_imm_q  <= imm;
        stage_base_q <= base_instr;
      end
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FDEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (stage_push),
    .din     (stage_entry),
    .pop     (fifo_pop),
    .dout    (head),
    .count   (fifo_cnt),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid     = ~fifo_empty;
  assign out_instr     = head.instr;
  assign out_err_range = head.err_range;
  assign out_err_align = head.err_align;
  assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
`timescale 1ns/1ps
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  imm_src;
  logic [31:0] imm;
  logic [31:0] base_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err_range;
  logic        out_err_align;
  logic [7:0]  err_count;

  int errors = 0;
  int checks = 0;

  imm_encoder #(.DEPTH(2)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .imm_src       (imm_src),
    .imm           (imm),
    .base_instr    (base_instr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_err_range (out_err_range),
    .out_err_align (out_err_align),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  // Decode-side extender, written from the instruction-set definition.
  function automatic logic [31:0] dec_imm(input logic [1:0] s, input logic [31:0] i);
    case (s)
      2'b00:   return {{20{i[31]}}, i[31:20]};
      2'b01:   return {{20{i[31]}}, i[31:25], i[11:7]};
      2'b10:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request presented for exactly one edge (block is idle when called).
  task automatic issue(input logic [1:0] s, input logic [31:0] i, input logic [31:0] b);
    in_valid   = 1'b1;
    imm_src    = s;
    imm        = i;
    base_instr = b;
    tick();
    in_valid   = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    imm_src = 2'b00; imm = '0; base_instr = '0;
    #2;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if ({out_instr, out_err_range, out_err_align} !== 34'h0) begin errors++; $display("FAIL reset_out_word: got %h %b%b want 0", out_instr, out_err_range, out_err_align); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_i();
    issue(2'b00, 32'hFFFFF800, 32'h00000013);
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL i_latency: out_valid got %b want 1", out_valid); end
    checks++; if (out_instr !== 32'h80000013) begin errors++; $display("FAIL i_instr: got %h want 80000013", out_instr); end
    checks++; if ({out_err_range, out_err_align} !== 2'b00) begin errors++; $display("FAIL i_flags: got %b%b want 00", out_err_range, out_err_align); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL i_err_count: got %0d want 0", err_count); end
    checks++; if (dec_imm(2'b00, out_instr) !== 32'hFFFFF800) begin errors++; $display("FAIL i_roundtrip: got %h want FFFFF800", dec_imm(2'b00, out_instr)); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL i_pop: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_s();
    issue(2'b01, 32'h000007FF, 32'h00002023);
    tick();
    checks++; if (out_instr !== 32'h7E002FA3 || out_valid !== 1'b1) begin errors++; $display("FAIL s_instr: got %h valid %b want 7E002FA3 valid 1", out_instr, out_valid); end
    checks++; if ({out_err_range, out_err_align} !== 2'b00) begin errors++; $display("FAIL s_flags: got %b%b want 00", out_err_range, out_err_align); end
    checks++; if (dec_imm(2'b01, out_instr) !== 32'h000007FF) begin errors++; $display("FAIL s_roundtrip: got %h want 000007FF", dec_imm(2'b01, out_instr)); end
    tick();
  endtask

  task automatic test_b();
    issue(2'b10, 32'hFFFFF000, 32'h00000063);
    tick();
    checks++; if (out_instr !== 32'h80000063 || {out_err_range, out_err_align} !== 2'b00) begin errors++; $display("FAIL b_neg: got %h %b%b want 80000063 00", out_instr, out_err_range, out_err_align); end
    checks++; if (dec_imm(2'b10, out_instr) !== 32'hFFFFF000) begin errors++; $display("FAIL b_roundtrip: got %h want FFFFF000", dec_imm(2'b10, out_instr)); end
    tick();
    issue(2'b10, 32'h00000801, 32'h00000063);
    tick();
    checks++; if (out_instr !== 32'h000000E3 || {out_err_range, out_err_align} !== 2'b01) begin errors++; $display("FAIL b_align: got %h %b%b want 000000E3 01", out_instr, out_err_range, out_err_align); end
    tick();
    issue(2'b10, 32'h00001000, 32'h00000063);
    tick();
    checks++; if (out_instr !== 32'h80000063 || {out_err_range, out_err_align} !== 2'b10) begin errors++; $display("FAIL b_range: got %h %b%b want 80000063 10", out_instr, out_err_range, out_err_align); end
    checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL b_err_count: got %0d want 2", err_count); end
    tick();
  endtask

  task automatic test_j();
    issue(2'b11, 32'h000FFFFE, 32'h0000006F);
    tick();
    checks++; if (out_instr !== 32'h7FFFF06F || {out_err_range, out_err_align} !== 2'b00) begin errors++; $display("FAIL j_instr: got %h %b%b want 7FFFF06F 00", out_instr, out_err_range, out_err_align); end
    checks++; if (dec_imm(2'b11, out_instr) !== 32'h000FFFFE) begin errors++; $display("FAIL j_roundtrip: got %h want 000FFFFE", dec_imm(2'b11, out_instr)); end
    tick();
    issue(2'b00, 32'h00000800, 32'h00000013);
    tick();
    checks++; if (out_instr !== 32'h80000013 || {out_err_range, out_err_align} !== 2'b10) begin errors++; $display("FAIL i_range_edge: got %h %b%b want 80000013 10", out_instr, out_err_range, out_err_align); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] vimm [3];
    logic [31:0] vexp [3];
    int sent;
    int unstable;
    logic acc;
    vimm[0] = 32'h11; vimm[1] = 32'h22; vimm[2] = 32'h33;
    vexp[0] = 32'h01100013; vexp[1] = 32'h02200013; vexp[2] = 32'h03300013;
    sent = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid   = 1'b1;
      imm_src    = 2'b00;
      imm        = vimm[(sent < 3) ? sent : 2];
      base_instr = 32'h00000013;
      acc = in_ready;
      tick();
      if (acc) sent++;
    end
    checks++; if (sent != 2) begin errors++; $display("FAIL bp_accepted: got %0d want 2", sent); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_instr !== vexp[0]) begin errors++; $display("FAIL bp_head: got %h valid %b want %h valid 1", out_instr, out_valid, vexp[0]); end
    unstable = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (out_valid !== 1'b1 || out_instr !== vexp[0] || out_err_range !== 1'b0) unstable++;
    end
    checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stable: %0d unstable cycles want 0", unstable); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_no_bypass: in_ready got %b want 0", in_ready); end
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_instr !== vexp[1]) begin errors++; $display("FAIL bp_second: got %h valid %b want %h valid 1", out_instr, out_valid, vexp[1]); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: out_valid got %b want 0", out_valid); end
    issue(2'b00, vimm[2], 32'h00000013);
    tick();
    checks++; if (out_instr !== vexp[2] || out_valid !== 1'b1) begin errors++; $display("FAIL bp_third: got %h valid %b want %h valid 1", out_instr, out_valid, vexp[2]); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] got [4];
    logic [31:0] want [4];
    int sent, ng, bad;
    logic acc;
    want[0] = 32'h00100013; want[1] = 32'h00200013;
    want[2] = 32'h00300013; want[3] = 32'h00400013;
    sent = 0; ng = 0; bad = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      if (out_valid === 1'b1) begin
        if (ng < 4) got[ng] = out_instr;
        ng++;
      end
      in_valid   = (sent < 4);
      imm_src    = 2'b00;
      imm        = 32'(sent + 1);
      base_instr = 32'h00000013;
      acc = in_valid & in_ready;
      tick();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    checks++; if (ng != 4) begin errors++; $display("FAIL b2b_count: got %0d words want 4", ng); end
    for (int k = 0; k < 4; k++) if (k < ng && got[k] !== want[k]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_order: %0d words out of order/wrong, first got %h want %h", bad, got[0], want[0]); end
    tick(); tick();
  endtask

  task automatic test_saturate_reset();
    int n, stale;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    imm_src    = 2'b01;
    imm        = 32'h00001000;
    base_instr = 32'h00002023;
    n = 0;
    for (int c = 0; c < 2000 && n < 300; c++) begin
      if (in_ready === 1'b1) n++;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (n != 300) begin errors++; $display("FAIL sat_accepts: got %0d want 300 (timeout)", n); end
    tick(); tick();
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_err_count: got %0d want 255", err_count); end
    in_valid = 1'b1;
    tick(); tick(); tick();
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL async_reset_hs: out_valid %b in_ready %b want 0 1", out_valid, in_ready); end
    checks++; if (err_count !== 8'd0 || out_instr !== 32'h0) begin errors++; $display("FAIL async_reset_state: err_count %0d out_instr %h want 0 0", err_count, out_instr); end
    in_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid !== 1'b0) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL reset_stale: %0d cycles with out_valid want 0", stale); end
    issue(2'b00, 32'h00000005, 32'h00000013);
    tick();
    checks++; if (out_instr !== 32'h00500013 || out_valid !== 1'b1 || err_count !== 8'd0) begin errors++; $display("FAIL post_reset: got %h valid %b cnt %0d want 00500013 1 0", out_instr, out_valid, err_count); end
    tick();
  endtask

  initial begin
    test_reset();
    test_i();
    test_s();
    test_b();
    test_j();
    test_backpressure();
    test_back_to_back();
    test_saturate_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
